// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
interface instr_encoder_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  op_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        out_err_o;

    // Encoder side.
    modport slave (
        input  in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_err_o
    );

    // Loader front end and instruction-memory side.
    modport master (
        output in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_addr_o, out_err_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes decoded RV32 field bundles into instruction words and queues them,
// tagged with sequential memory addresses, in a small FIFO.
module instr_encoder #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    instr_encoder_if.slave    bus,
    output logic [7:0]        err_cnt_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_XOR  = 4'd1,
        OP_SLL  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_MUL  = 4'd5,
        OP_ADDI = 4'd6,
        OP_SRAI = 4'd7,
        OP_LW   = 4'd8,
        OP_SW   = 4'd9,
        OP_BEQ  = 4'd10
    } op_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_addr  [DEPTH];
    logic             mem_err   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      addr_cnt;

    logic             push;
    logic             pop;
    logic [31:0]      enc_word;
    logic             enc_err;
    logic [31:0]      word_raw;
    logic             bad;
    logic signed [31:0] imm_s;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;

    assign rd    = bus.rd_i;
    assign rs1   = bus.rs1_i;
    assign rs2   = bus.rs2_i;
    assign imm   = bus.imm_i;
    assign imm_s = $signed(bus.imm_i);

    assign bus.in_ready_o  = (count < DEPTH_C);
    assign bus.out_valid_o = (count != '0);
    assign bus.out_instr_o = mem_instr[rd_ptr];
    assign bus.out_addr_o  = mem_addr[rd_ptr];
    assign bus.out_err_o   = mem_err[rd_ptr];

    assign push = bus.in_valid_i && bus.in_ready_o;
    assign pop  = bus.out_valid_o && bus.out_ready_i;

    // Field assembly and range checking; errored bundles become a NOP.
    always_comb begin
        word_raw = NOP;
        bad      = 1'b0;
        case (bus.op_i)
            OP_AND:  word_raw = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
            OP_XOR:  word_raw = {7'b0000000, rs2, rs1, 3'b100, rd, OPC_R};
            OP_SLL:  word_raw = {7'b0000000, rs2, rs1, 3'b001, rd, OPC_R};
            OP_ADD:  word_raw = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
            OP_SUB:  word_raw = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
            OP_MUL:  word_raw = {7'b0000001, rs2, rs1, 3'b000, rd, OPC_R};
            OP_ADDI: begin
                word_raw = {imm[11:0], rs1, 3'b000, rd, OPC_I_ALU};
                bad      = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            OP_SRAI: begin
                word_raw = {7'b0100000, imm[4:0], rs1, 3'b101, rd, OPC_I_ALU};
                bad      = (imm_s < 32'sd0) || (imm_s > 32'sd31);
            end
            OP_LW: begin
                word_raw = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
                bad      = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            OP_SW: begin
                word_raw = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
                bad      = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            OP_BEQ: begin
                word_raw = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                            imm[4:1], imm[11], OPC_BRANCH};
                bad      = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
            end
            default: bad = 1'b1;
        endcase
        enc_err  = bad;
        enc_word = bad ? NOP : word_raw;
    end

    // FIFO storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_addr[i]  <= '0;
                mem_err[i]   <= 1'b0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= enc_word;
            mem_addr[wr_ptr]  <= addr_cnt;
            mem_err[wr_ptr]   <= enc_err;
        end
    end

    // Pointers, occupancy, address counter and saturating error counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            addr_cnt  <= BASE_ADDR;
            err_cnt_o <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                addr_cnt <= addr_cnt + 32'd4;
                if (enc_err && (err_cnt_o != 8'hFF)) begin
                    err_cnt_o <= err_cnt_o + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] err_cnt_o;
    int         checks = 0;
    int         errors = 0;

    instr_encoder_if bus();

    instr_encoder #(.DEPTH(2), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        bus.in_valid_i = 1'b1;
        bus.op_i  = op;
        bus.rd_i  = rd;
        bus.rs1_i = rs1;
        bus.rs2_i = rs2;
        bus.imm_i = imm;
    endtask

    // With out_ready high, each pushed word is at the head right after its edge.
    task automatic stream(input string tag, input logic [3:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] e_instr, input logic [31:0] e_addr, input logic e_err);
        drive(op, rd, rs1, rs2, imm);
        chk({tag, "_rdy"}, {31'd0, bus.in_ready_o}, 32'd1);
        step();
        chk({tag, "_vld"}, {31'd0, bus.out_valid_o}, 32'd1);
        chk({tag, "_ins"}, bus.out_instr_o, e_instr);
        chk({tag, "_adr"}, bus.out_addr_o, e_addr);
        chk({tag, "_err"}, {31'd0, bus.out_err_o}, {31'd0, e_err});
    endtask

    initial begin
        rst_i           = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.op_i  = '0;
        bus.rd_i  = '0;
        bus.rs1_i = '0;
        bus.rs2_i = '0;
        bus.imm_i = '0;
        step();
        step();
        rst_i = 1'b0;

        // Reset state
        chk("rst_rdy", {31'd0, bus.in_ready_o}, 32'd1);
        chk("rst_vld", {31'd0, bus.out_valid_o}, 32'd0);
        chk("rst_ins", bus.out_instr_o, 32'd0);
        chk("rst_adr", bus.out_addr_o, 32'd0);
        chk("rst_err", {31'd0, bus.out_err_o}, 32'd0);
        chk("rst_ecnt", {24'd0, err_cnt_o}, 32'd0);

        // Single ADD, visible the cycle after acceptance
        drive(4'd3, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        bus.in_valid_i = 1'b0;
        chk("add_vld", {31'd0, bus.out_valid_o}, 32'd1);
        chk("add_ins", bus.out_instr_o, 32'h002081B3);
        chk("add_adr", bus.out_addr_o, 32'd0);
        chk("add_err", {31'd0, bus.out_err_o}, 32'd0);
        bus.out_ready_i = 1'b1;
        step();
        chk("add_pop", {31'd0, bus.out_valid_o}, 32'd0);

        // Fresh reset so the stream starts at address 0
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;

        // Back-to-back stream, one word per cycle
        stream("addi",   4'd6,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00093, 32'd0,  1'b0);
        stream("sw",     4'd9,  5'd0, 5'd2, 5'd5, 32'd8,         32'h00512423, 32'd4,  1'b0);
        stream("beq",    4'd10, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE208CE3, 32'd8,  1'b0);
        stream("srai",   4'd7,  5'd4, 5'd4, 5'd0, 32'd3,         32'h40325213, 32'd12, 1'b0);
        stream("e_addi", 4'd6,  5'd1, 5'd0, 5'd0, 32'd2048,      32'h00000013, 32'd16, 1'b1);
        stream("e_beq",  4'd10, 5'd0, 5'd1, 5'd2, 32'd3,         32'h00000013, 32'd20, 1'b1);
        stream("e_op12", 4'd12, 5'd1, 5'd1, 5'd1, 32'd0,         32'h00000013, 32'd24, 1'b1);
        chk("ecnt3", {24'd0, err_cnt_o}, 32'd3);
        stream("e_sr32", 4'd7,  5'd4, 5'd4, 5'd0, 32'd32,        32'h00000013, 32'd28, 1'b1);
        stream("e_srn",  4'd7,  5'd4, 5'd4, 5'd0, 32'hFFFF_FFFF, 32'h00000013, 32'd32, 1'b1);
        stream("beqmin", 4'd10, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 32'h80208063, 32'd36, 1'b0);
        stream("beqmax", 4'd10, 5'd0, 5'd1, 5'd2, 32'd4094,      32'h7E208FE3, 32'd40, 1'b0);
        stream("e_b4k",  4'd10, 5'd0, 5'd1, 5'd2, 32'd4096,      32'h00000013, 32'd44, 1'b1);
        chk("ecnt6", {24'd0, err_cnt_o}, 32'd6);
        stream("lwmin",  4'd8,  5'd5, 5'd6, 5'd0, 32'hFFFF_F800, 32'h80032283, 32'd48, 1'b0);
        stream("sub",    4'd4,  5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3, 32'd52, 1'b0);
        stream("mul",    4'd5,  5'd3, 5'd1, 5'd2, 32'd0,         32'h022081B3, 32'd56, 1'b0);
        stream("xor",    4'd1,  5'd3, 5'd1, 5'd2, 32'd0,         32'h0020C1B3, 32'd60, 1'b0);
        stream("and",    4'd0,  5'd3, 5'd1, 5'd2, 32'd0,         32'h0020F1B3, 32'd64, 1'b0);
        stream("sll",    4'd2,  5'd3, 5'd1, 5'd2, 32'd0,         32'h002091B3, 32'd68, 1'b0);
        bus.in_valid_i = 1'b0;
        step();
        chk("strm_end", {31'd0, bus.out_valid_o}, 32'd0);

        // Backpressure: fill, hold third bundle, release one pop
        bus.out_ready_i = 1'b0;
        drive(4'd3, 5'd1, 5'd1, 5'd2, 32'd0);
        step();
        drive(4'd3, 5'd2, 5'd1, 5'd2, 32'd0);
        step();
        drive(4'd3, 5'd3, 5'd1, 5'd2, 32'd0);
        chk("full_rdy", {31'd0, bus.in_ready_o}, 32'd0);
        step();
        chk("held_rdy", {31'd0, bus.in_ready_o}, 32'd0);
        chk("held_a",   bus.out_instr_o, 32'h002080B3);
        chk("held_aad", bus.out_addr_o, 32'd72);
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
        chk("free_rdy", {31'd0, bus.in_ready_o}, 32'd1);
        chk("b_ins",    bus.out_instr_o, 32'h00208133);
        chk("b_adr",    bus.out_addr_o, 32'd76);
        step();
        bus.in_valid_i = 1'b0;
        chk("refull",   {31'd0, bus.in_ready_o}, 32'd0);
        chk("b_still",  bus.out_instr_o, 32'h00208133);
        bus.out_ready_i = 1'b1;
        step();
        chk("c_ins",    bus.out_instr_o, 32'h002081B3);
        chk("c_adr",    bus.out_addr_o, 32'd80);
        step();
        chk("bp_empty", {31'd0, bus.out_valid_o}, 32'd0);

        // Reset with two entries buffered and a coincident push
        bus.out_ready_i = 1'b0;
        drive(4'd15, 5'd1, 5'd1, 5'd1, 32'd0);
        step();
        drive(4'd3, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        chk("pre_rst_vld", {31'd0, bus.out_valid_o}, 32'd1);
        chk("pre_rst_ecnt", {24'd0, err_cnt_o}, 32'd7);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("mrst_vld",  {31'd0, bus.out_valid_o}, 32'd0);
        chk("mrst_rdy",  {31'd0, bus.in_ready_o}, 32'd1);
        chk("mrst_ecnt", {24'd0, err_cnt_o}, 32'd0);
        chk("mrst_ins",  bus.out_instr_o, 32'd0);
        drive(4'd3, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        bus.in_valid_i = 1'b0;
        chk("post_ins",  bus.out_instr_o, 32'h002081B3);
        chk("post_adr",  bus.out_addr_o, 32'd0);
        chk("post_ecnt", {24'd0, err_cnt_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
